// File: rtl/fc_input_loader_if.sv
// Stream-in / vector-out bundle between the upstream producer, the loader and the FC layer.
// master: producer + consumer side (drives beats and x_ready).
// slave:  the loader itself.
interface fc_input_loader_if #(
    parameter int WIDTH = 8,
    parameter int IN    = 128
);
    // Upstream activation stream
    logic [WIDTH-1:0] s_data;
    logic             s_valid;
    logic             s_last;
    logic             s_ready;

    // Assembled vector towards the layer
    logic [WIDTH-1:0] x [0:IN-1];
    logic             x_valid;
    logic             x_ready;
    logic             frame_err;

    modport master (
        output s_data,
        output s_valid,
        output s_last,
        output x_ready,
        input  s_ready,
        input  x,
        input  x_valid,
        input  frame_err
    );

    modport slave (
        input  s_data,
        input  s_valid,
        input  s_last,
        input  x_ready,
        output s_ready,
        output x,
        output x_valid,
        output frame_err
    );
endinterface

// File: rtl/fc_input_loader.sv
// Serial-to-parallel activation loader: collects IN beats into a register bank, checks the
// frame length against s_last, and presents the full vector with a valid/ready handshake.
module fc_input_loader #(
    parameter int WIDTH = 8,
    parameter int IN    = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    fc_input_loader_if.slave  bus
);
    localparam int CntW = (IN > 1) ? $clog2(IN) : 1;

    typedef enum logic [1:0] {
        StFill = 2'd0,
        StHold = 2'd1,
        StDrop = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] x_q [IN];
    logic             x_valid_q;
    logic             frame_err_q, frame_err_d;
    logic             s_ready;
    logic             accept;
    logic             last_slot;
    logic             wr_en;

    assign accept    = bus.s_valid && s_ready;
    assign last_slot = (cnt_q == CntW'(IN - 1));

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StFill;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: frame completes in HOLD, overruns in DROP, short frames stay in FILL
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFill: begin
                if (accept && last_slot) begin
                    state_d = bus.s_last ? StHold : StDrop;
                end
            end
            StDrop: begin
                if (accept && bus.s_last) begin
                    state_d = StFill;
                end
            end
            StHold: begin
                // The beat offered in the acknowledge cycle is not taken: one bubble
                if (bus.x_ready) begin
                    state_d = StFill;
                end
            end
            default: state_d = StFill;
        endcase
    end

    // Outputs decoded from registered state only (no path from s_valid or x_ready)
    always_comb begin
        s_ready = (state_q != StHold);
    end

    // Write index, bank write enable and error detection for the FILL state
    always_comb begin
        cnt_d       = cnt_q;
        wr_en       = 1'b0;
        frame_err_d = 1'b0;
        if (state_q == StFill && accept) begin
            if (!last_slot) begin
                if (bus.s_last) begin
                    // Short frame: discard the beat and restart
                    cnt_d       = '0;
                    frame_err_d = 1'b1;
                end else begin
                    wr_en = 1'b1;
                    cnt_d = cnt_q + CntW'(1);
                end
            end else begin
                cnt_d = '0;
                if (bus.s_last) begin
                    wr_en = 1'b1;
                end else begin
                    // Long frame: flag once here, DROP swallows the rest silently
                    frame_err_d = 1'b1;
                end
            end
        end
    end

    // Register bank; only written in FILL, so it stays frozen while HOLD presents it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < IN; i++) begin
                x_q[i] <= '0;
            end
        end else if (wr_en) begin
            x_q[cnt_q] <= bus.s_data;
        end
    end

    // Index and registered status flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            x_valid_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            x_valid_q   <= (state_d == StHold);
            frame_err_q <= frame_err_d;
        end
    end

    assign bus.s_ready   = s_ready;
    assign bus.x_valid   = x_valid_q;
    assign bus.frame_err = frame_err_q;
    assign bus.x         = x_q;
endmodule
